regfile_wb_queue: RTL and testbench
===================================

Name: regfile_wb_queue

Overview:
- Writer-side front end for the 32x32 register file's single write port. Serialises up to two writeback results per cycle (ALU and memory/load) into an in-order queue.
- Drains one entry per cycle onto the register file's WriteReg1/WriteData1/Write1 inputs.
- Forwards queued, not-yet-committed values to the three register read lookups so readers never observe stale data.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- AW, 5, register index width.
- DW, 32, data width.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- AluValid  input  1  ALU result present this cycle.
- AluReg  input  AW  ALU destination register.
- AluData  input  DW  ALU result.
- MemValid  input  1  memory/load result present this cycle.
- MemReg  input  AW  memory destination register.
- MemData  input  DW  memory result.
- InReady  output  1  queue can accept two entries this cycle.
- WriteReg1  output  AW  register file write index.
- WriteData1  output  DW  register file write data.
- Write1  output  1  register file write enable.
- RegA1, RegB1, RegC1  input  AW each  read indices being looked up.
- FwdHitA, FwdHitB, FwdHitC  output  1 each  queued value exists for that index.
- FwdDataA, FwdDataB, FwdDataC  output  DW each  youngest queued value for that index.
- Count  output  log2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: circular buffer of DEPTH entries {reg, data}, with head pointer, tail pointer and Count.
- Reset: RESET high at a rising edge sets head=0, tail=0, Count=0. All pending entries are discarded. Reset mid-drain aborts the queue; nothing further is written.
- Outputs during and after reset: Write1=0, WriteReg1=0, WriteData1=0, InReady=1, all FwdHit=0, all FwdData=0.
- InReady: combinational, equal to (Count <= DEPTH-2). It does not depend on the valid inputs.
- Accept rule:
  - A producer is accepted only if its Valid=1 and InReady=1.
  - Valid while InReady=0 is a producer protocol violation; the input is ignored and not queued.
  - An input with Reg==0 is accepted but never enqueued (r0 is hardwired zero).
- Enqueue order when both producers are accepted in the same cycle:
  - The Mem entry is enqueued first (older instruction), then the ALU entry.
  - If both target the same nonzero register, both are queued. The ALU value is therefore the last committed value.
- Drain:
  - Write1 = (Count != 0).
  - WriteReg1 and WriteData1 come combinationally from the head entry. They are 0 when the queue is empty.
  - When Write1=1 the head is popped at the same rising edge. Drain rate is exactly one entry per cycle with no stall input; the register file always accepts.
- Occupancy: next Count = Count + pushes(0..2) - pop(0/1). Push and pop in the same cycle are legal at any occupancy permitted by InReady. Count never exceeds DEPTH.
- Pointer wrap: head and tail wrap modulo DEPTH. Entry validity is derived from the head/Count window, not from stale slot contents.
- Latency: a value accepted at edge N is written to the register file at the earliest at edge N+1, i.e. it is presented on Write1 during cycle N+1 when the queue was empty.
- Forwarding (per port X in {A,B,C}, combinational):
  - FwdHitX=1 iff RegX1 != 0 and some live entry, including the head being written this cycle, has reg == RegX1.
  - FwdDataX is the data of the youngest such entry (closest to tail); 0 when there is no hit.
  - Entries being enqueued in the current cycle are not visible until the next cycle.
- Write ordering: no reordering and no coalescing. The register file receives writes in exact accept order.

Test Plan:
- Reset then idle: RESET=1 for 2 cycles, then all Valid=0 for 5 cycles → Write1=0, Count=0, InReady=1 every cycle; FwdHitA/B/C=0.
- Single write: AluValid=1, AluReg=5, AluData=0xDEADBEEF for one cycle → next cycle Write1=1, WriteReg1=5, WriteData1=0xDEADBEEF, Count=1; following cycle Write1=0, Count=0.
- Dual push with same destination: MemReg=7/MemData=0x11 and AluReg=7/AluData=0x22 in one cycle, RegA1=7 → Write1 sequence: (7,0x11) then (7,0x22). FwdDataA=0x22 while both are queued, 0x22 while only the ALU entry remains, FwdHitA=0 afterwards.
- Backpressure and wrap: push two entries per cycle for 6 cycles, honouring InReady (regs 1..12, data = reg*0x100) → InReady deasserts when Count=3; Count never exceeds 4; all 12 writes appear in order 1..12 with the correct data across pointer wrap.
- r0 filter: AluReg=0/AluData=0x55 together with MemReg=3/MemData=0x66 → only (3,0x66) is written; FwdHit for RegB1=0 stays 0.
- Reset mid-drain: fill to Count=3, assert RESET for one cycle → the cycle after reset has Write1=0, Count=0, and no further writes of the old entries occur.

Source files
------------

// File: rtl/regfile_wb_queue.sv
// Writeback queue in front of the register file write port.
// Serialises ALU/Mem results in order and forwards queued values to readers.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   AluValid,
  input  logic [AW-1:0]          AluReg,
  input  logic [DW-1:0]          AluData,
  input  logic                   MemValid,
  input  logic [AW-1:0]          MemReg,
  input  logic [DW-1:0]          MemData,
  output logic                   InReady,
  output logic [AW-1:0]          WriteReg1,
  output logic [DW-1:0]          WriteData1,
  output logic                   Write1,
  input  logic [AW-1:0]          RegA1,
  input  logic [AW-1:0]          RegB1,
  input  logic [AW-1:0]          RegC1,
  output logic                   FwdHitA,
  output logic                   FwdHitB,
  output logic                   FwdHitC,
  output logic [DW-1:0]          FwdDataA,
  output logic [DW-1:0]          FwdDataB,
  output logic [DW-1:0]          FwdDataC,
  output logic [$clog2(DEPTH):0] Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] rg;
    logic [DW-1:0] data;
  } entry_t;

  typedef struct packed {
    logic          hit;
    logic [DW-1:0] data;
  } fwd_t;

  entry_t        slots [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;

  logic          ready;
  logic          memAcc;
  logic          aluAcc;
  logic [1:0]    pushes;
  logic          pop;
  logic [PW-1:0] aluSlot;
  fwd_t          fwdA;
  fwd_t          fwdB;
  fwd_t          fwdC;

  assign ready   = cnt <= CW'(DEPTH - 2);
  assign memAcc  = MemValid && ready && (MemReg != '0);
  assign aluAcc  = AluValid && ready && (AluReg != '0);
  assign pushes  = {1'b0, memAcc} + {1'b0, aluAcc};
  assign pop     = cnt != '0;
  // ALU entry lands behind the Mem entry when both are pushed
  assign aluSlot = tail + PW'(memAcc);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + PW'(pop);
      tail <= tail + PW'(pushes);
      cnt  <= cnt + CW'(pushes) - CW'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (memAcc) slots[tail] <= '{rg: MemReg, data: MemData};
      if (aluAcc) slots[aluSlot] <= '{rg: AluReg, data: AluData};
    end
  end

  // Walk oldest to youngest so the youngest match wins
  function automatic fwd_t lookup(input logic [AW-1:0] r);
    fwd_t          res;
    logic [PW-1:0] idx;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < cnt && slots[idx].rg == r) begin
        res.hit  = 1'b1;
        res.data = slots[idx].data;
      end
    end
    if (RESET || r == '0) res = '0;
    return res;
  endfunction

  always_comb begin
    fwdA = lookup(RegA1);
    fwdB = lookup(RegB1);
    fwdC = lookup(RegC1);
  end

  assign FwdHitA  = fwdA.hit;
  assign FwdHitB  = fwdB.hit;
  assign FwdHitC  = fwdC.hit;
  assign FwdDataA = fwdA.data;
  assign FwdDataB = fwdB.data;
  assign FwdDataC = fwdC.data;

  assign InReady    = RESET || ready;
  assign Write1     = !RESET && pop;
  assign WriteReg1  = Write1 ? slots[head].rg : '0;
  assign WriteData1 = Write1 ? slots[head].data : '0;
  assign Count      = cnt;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed self-checking bench for regfile_wb_queue.
// One task per scenario, each with inline comparisons.
module tb_regfile_wb_queue;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        AluValid;
  logic [4:0]  AluReg;
  logic [31:0] AluData;
  logic        MemValid;
  logic [4:0]  MemReg;
  logic [31:0] MemData;
  logic        InReady;
  logic [4:0]  WriteReg1;
  logic [31:0] WriteData1;
  logic        Write1;
  logic [4:0]  RegA1, RegB1, RegC1;
  logic        FwdHitA, FwdHitB, FwdHitC;
  logic [31:0] FwdDataA, FwdDataB, FwdDataC;
  logic [2:0]  Count;

  int checks = 0;
  int errors = 0;

  regfile_wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .CLK(CLK), .RESET(RESET),
    .AluValid(AluValid), .AluReg(AluReg), .AluData(AluData),
    .MemValid(MemValid), .MemReg(MemReg), .MemData(MemData),
    .InReady(InReady),
    .WriteReg1(WriteReg1), .WriteData1(WriteData1), .Write1(Write1),
    .RegA1(RegA1), .RegB1(RegB1), .RegC1(RegC1),
    .FwdHitA(FwdHitA), .FwdHitB(FwdHitB), .FwdHitC(FwdHitC),
    .FwdDataA(FwdDataA), .FwdDataB(FwdDataB), .FwdDataC(FwdDataC),
    .Count(Count)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    AluValid = 0; AluReg = 0; AluData = 0;
    MemValid = 0; MemReg = 0; MemData = 0;
  endtask

  task automatic test_reset();
    RESET = 1;
    idle_inputs();
    RegA1 = 1; RegB1 = 2; RegC1 = 3;
    tick();
    tick();
    checks++;
    if (Write1 !== 1'b0 || InReady !== 1'b1 || Count !== 3'd0) begin
      errors++;
      $display("FAIL reset_hold: W=%b R=%b C=%0d want 0 1 0", Write1, InReady, Count);
    end
    RESET = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (Write1 !== 1'b0 || Count !== 3'd0 || InReady !== 1'b1 ||
          {FwdHitA, FwdHitB, FwdHitC} !== 3'b000 ||
          WriteReg1 !== 5'd0 || WriteData1 !== 32'd0) begin
        errors++;
        $display("FAIL idle_%0d: W=%b C=%0d R=%b hits=%b%b%b want 0 0 1 000",
                 i, Write1, Count, InReady, FwdHitA, FwdHitB, FwdHitC);
      end
    end
  endtask

  task automatic test_single();
    AluValid = 1; AluReg = 5; AluData = 32'hDEADBEEF;
    tick();
    idle_inputs();
    checks++;
    if (Write1 !== 1'b1 || WriteReg1 !== 5'd5 ||
        WriteData1 !== 32'hDEADBEEF || Count !== 3'd1) begin
      errors++;
      $display("FAIL single_write: W=%b r=%0d d=%h C=%0d want 1 5 deadbeef 1",
               Write1, WriteReg1, WriteData1, Count);
    end
    tick();
    checks++;
    if (Write1 !== 1'b0 || Count !== 3'd0) begin
      errors++;
      $display("FAIL single_done: W=%b C=%0d want 0 0", Write1, Count);
    end
  endtask

  task automatic test_same_dest();
    MemValid = 1; MemReg = 7; MemData = 32'h11;
    AluValid = 1; AluReg = 7; AluData = 32'h22;
    RegA1 = 7;
    checks++;
    if (FwdHitA !== 1'b0) begin
      errors++;
      $display("FAIL same_pre_visible: hit=%b want 0", FwdHitA);
    end
    tick();
    idle_inputs();
    checks++;
    if (Count !== 3'd2 || Write1 !== 1'b1 || WriteReg1 !== 5'd7 ||
        WriteData1 !== 32'h11 || FwdHitA !== 1'b1 || FwdDataA !== 32'h22) begin
      errors++;
      $display("FAIL same_first: C=%0d W=%b r=%0d d=%h hit=%b fd=%h want 2 1 7 11 1 22",
               Count, Write1, WriteReg1, WriteData1, FwdHitA, FwdDataA);
    end
    tick();
    checks++;
    if (Count !== 3'd1 || Write1 !== 1'b1 || WriteReg1 !== 5'd7 ||
        WriteData1 !== 32'h22 || FwdHitA !== 1'b1 || FwdDataA !== 32'h22) begin
      errors++;
      $display("FAIL same_second: C=%0d W=%b r=%0d d=%h hit=%b fd=%h want 1 1 7 22 1 22",
               Count, Write1, WriteReg1, WriteData1, FwdHitA, FwdDataA);
    end
    tick();
    checks++;
    if (Count !== 3'd0 || Write1 !== 1'b0 || FwdHitA !== 1'b0 || FwdDataA !== 32'd0) begin
      errors++;
      $display("FAIL same_empty: C=%0d W=%b hit=%b fd=%h want 0 0 0 0",
               Count, Write1, FwdHitA, FwdDataA);
    end
    RegA1 = 1;
  endtask

  task automatic test_backpressure();
    logic [4:0] expQ[$];
    int expCount = 0;
    int nextReg  = 1;
    int writes   = 0;
    int cyc      = 0;
    bool_loop: while ((nextReg <= 12 || expCount != 0) && cyc < 40) begin
      logic expReady;
      logic pop;
      int push;
      expReady = (expCount <= 2);
      pop = (expCount != 0);
      checks++;
      if (Count !== 3'(expCount) || InReady !== expReady || Write1 !== pop) begin
        errors++;
        $display("FAIL bp_state_%0d: C=%0d R=%b W=%b want %0d %b %b",
                 cyc, Count, InReady, Write1, expCount, expReady, pop);
      end
      if (pop) begin
        checks++;
        if (WriteReg1 !== expQ[0] || WriteData1 !== {19'd0, expQ[0], 8'd0}) begin
          errors++;
          $display("FAIL bp_write_%0d: r=%0d d=%h want %0d %h",
                   writes, WriteReg1, WriteData1, expQ[0], {19'd0, expQ[0], 8'd0});
        end
        void'(expQ.pop_front());
        writes++;
      end
      push = 0;
      idle_inputs();
      if (expReady && nextReg <= 12) begin
        MemValid = 1; MemReg = 5'(nextReg);     MemData = 32'(nextReg) * 32'h100;
        AluValid = 1; AluReg = 5'(nextReg + 1); AluData = 32'(nextReg + 1) * 32'h100;
        expQ.push_back(5'(nextReg));
        expQ.push_back(5'(nextReg + 1));
        nextReg += 2;
        push = 2;
      end else if (nextReg <= 12) begin
        MemValid = 1; MemReg = 5'd31; MemData = 32'hBAD;
      end
      expCount = expCount + push - (pop ? 1 : 0);
      tick();
      cyc++;
    end
    idle_inputs();
    checks++;
    if (writes != 12 || cyc >= 40) begin
      errors++;
      $display("FAIL bp_total: writes=%0d cycles=%0d want 12 <40", writes, cyc);
    end
    checks++;
    if (Write1 !== 1'b0 || Count !== 3'd0) begin
      errors++;
      $display("FAIL bp_drained: W=%b C=%0d want 0 0", Write1, Count);
    end
  endtask

  task automatic test_r0();
    AluValid = 1; AluReg = 0; AluData = 32'h55;
    MemValid = 1; MemReg = 3; MemData = 32'h66;
    RegA1 = 3; RegB1 = 0;
    tick();
    idle_inputs();
    checks++;
    if (Count !== 3'd1 || Write1 !== 1'b1 || WriteReg1 !== 5'd3 ||
        WriteData1 !== 32'h66) begin
      errors++;
      $display("FAIL r0_write: C=%0d W=%b r=%0d d=%h want 1 1 3 66",
               Count, Write1, WriteReg1, WriteData1);
    end
    checks++;
    if (FwdHitB !== 1'b0 || FwdHitA !== 1'b1 || FwdDataA !== 32'h66) begin
      errors++;
      $display("FAIL r0_fwd: hitB=%b hitA=%b fdA=%h want 0 1 66",
               FwdHitB, FwdHitA, FwdDataA);
    end
    tick();
    checks++;
    if (Write1 !== 1'b0 || Count !== 3'd0) begin
      errors++;
      $display("FAIL r0_after: W=%b C=%0d want 0 0", Write1, Count);
    end
  endtask

  task automatic test_reset_mid();
    MemValid = 1; MemReg = 8;  MemData = 32'h800;
    AluValid = 1; AluReg = 9;  AluData = 32'h900;
    tick();
    MemReg = 10; MemData = 32'hA00;
    AluReg = 11; AluData = 32'hB00;
    tick();
    idle_inputs();
    checks++;
    if (Count !== 3'd3) begin
      errors++;
      $display("FAIL mid_fill: C=%0d want 3", Count);
    end
    RESET = 1;
    #1;
    checks++;
    if (Write1 !== 1'b0 || InReady !== 1'b1) begin
      errors++;
      $display("FAIL mid_during: W=%b R=%b want 0 1", Write1, InReady);
    end
    tick();
    RESET = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (Write1 !== 1'b0 || Count !== 3'd0 || WriteReg1 !== 5'd0) begin
        errors++;
        $display("FAIL mid_after_%0d: W=%b C=%0d r=%0d want 0 0 0",
                 i, Write1, Count, WriteReg1);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_same_dest();
    test_backpressure();
    test_r0();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
